cursor_plotter: RTL

//  Upstream pixel source for vga_adapter. Drives x/y/plot/colour for the etch-a-sketch.

---
 rtl/cursor_plotter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/cursor_plotter.sv
// cursor_plotter
// Pixel source for vga_adapter in the etch-a-sketch. After reset or a clear
// request it sweeps the whole 160x120 frame to black. It then parks a cursor
// at the home position and moves it one pixel per debounced, auto-repeating
// key step event, plotting each new cursor position.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   key_n      active-low direction keys: [3]=left [2]=right [1]=up [0]=down
//   clear      synchronous pulse, restarts the frame sweep from (0,0)
//   colour_in  drawing colour used for the home pixel and cursor moves
//   vga_x      pixel column
//   vga_y      pixel row
//   colour     pixel colour
//   plot_en    write strobe, one cycle per pixel
//   busy       high while the sweep is writing pixels
module cursor_plotter #(
  parameter int X_MAX           = 159,
  parameter int Y_MAX           = 119,
  parameter int X_START         = 80,
  parameter int Y_START         = 60,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       clear,
  input  logic [2:0] colour_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot_en,
  output logic       busy
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [7:0]    X_LAST   = 8'(X_MAX);
  localparam logic [6:0]    Y_LAST   = 7'(Y_MAX);
  localparam logic [7:0]    X_HOME   = 8'(X_START);
  localparam logic [6:0]    Y_HOME   = 7'(Y_START);

  typedef enum logic [1:0] {SWEEP, HOME, IDLE, PLOT} state_t;

  // Key conditioning state
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    armed;
  logic [CW-1:0] cnt [4];
  logic [3:0]    step;

  // FSM and datapath state
  state_t     state;
  state_t     state_n;
  logic [7:0] sweep_x;
  logic [7:0] sweep_x_n;
  logic [6:0] sweep_y;
  logic [6:0] sweep_y_n;
  logic [7:0] x_n;
  logic [6:0] y_n;
  logic [2:0] colour_n;
  logic       plot_n;
  logic       busy_n;
  logic [7:0] sx_base;
  logic [6:0] sy_base;

  // Cursor move candidate
  logic [7:0] move_x;
  logic [6:0] move_y;
  logic       moved;

  // A key fires its first step once the debounce count is reached; after that
  // (armed) it fires every repeat period for as long as it stays pressed.
  always_comb begin
    step = '0;
    for (int i = 0; i < 4; i++) begin
      if (!sync2[i]) begin
        step[i] = armed[i] ? (cnt[i] == REP_LAST) : (cnt[i] == DEB_LAST);
      end
    end
  end

  // Keys are asynchronous, so each passes through two flops before its
  // counter. Any released sample clears the counter and disarms the key, so a
  // short bounce can never produce a step. Counters run in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      armed <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i]) begin
          cnt[i]   <= '0;
          armed[i] <= 1'b0;
        end else if (step[i]) begin
          cnt[i]   <= '0;
          armed[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Opposing steps on one axis cancel. Each axis saturates at the frame edge
  // rather than wrapping.
  always_comb begin
    move_x = vga_x;
    move_y = vga_y;
    if (step[2] && !step[3] && vga_x != X_LAST) begin
      move_x = vga_x + 8'd1;
    end else if (step[3] && !step[2] && vga_x != 8'd0) begin
      move_x = vga_x - 8'd1;
    end
    if (step[0] && !step[1] && vga_y != Y_LAST) begin
      move_y = vga_y + 7'd1;
    end else if (step[1] && !step[0] && vga_y != 7'd0) begin
      move_y = vga_y - 7'd1;
    end
    moved = (move_x != vga_x) || (move_y != vga_y);
  end

  // Next-state and next-output logic. Outputs are registered, so a decision
  // made in cycle N is seen on the pins in cycle N+1. A clear behaves like a
  // sweep step taken from (0,0), so the pixel after the clear cycle is (0,0)
  // regardless of what the FSM was doing.
  always_comb begin
    state_n   = state;
    sweep_x_n = sweep_x;
    sweep_y_n = sweep_y;
    x_n       = vga_x;
    y_n       = vga_y;
    colour_n  = colour;
    plot_n    = 1'b0;
    busy_n    = 1'b0;
    sx_base   = clear ? 8'd0 : sweep_x;
    sy_base   = clear ? 7'd0 : sweep_y;

    if (clear || state == SWEEP) begin
      x_n      = sx_base;
      y_n      = sy_base;
      colour_n = 3'd0;
      plot_n   = 1'b1;
      busy_n   = 1'b1;
      state_n  = SWEEP;
      if (sx_base == X_LAST) begin
        sweep_x_n = 8'd0;
        if (sy_base == Y_LAST) begin
          sweep_y_n = 7'd0;
          state_n   = HOME;
        end else begin
          sweep_y_n = sy_base + 7'd1;
        end
      end else begin
        sweep_x_n = sx_base + 8'd1;
        sweep_y_n = sy_base;
      end
    end else begin
      case (state)
        HOME: begin
          x_n      = X_HOME;
          y_n      = Y_HOME;
          colour_n = colour_in;
          plot_n   = 1'b1;
          state_n  = IDLE;
        end
        IDLE: begin
          if (moved) begin
            x_n      = move_x;
            y_n      = move_y;
            colour_n = colour_in;
            plot_n   = 1'b1;
            state_n  = PLOT;
          end
        end
        PLOT: begin
          state_n = IDLE;
        end
        default: begin
          state_n = SWEEP;
        end
      endcase
    end
  end

  // State, sweep position and registered pixel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SWEEP;
      sweep_x <= 8'd0;
      sweep_y <= 7'd0;
      vga_x   <= 8'd0;
      vga_y   <= 7'd0;
      colour  <= 3'd0;
      plot_en <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      sweep_x <= sweep_x_n;
      sweep_y <= sweep_y_n;
      vga_x   <= x_n;
      vga_y   <= y_n;
      colour  <= colour_n;
      plot_en <= plot_n;
      busy    <= busy_n;
    end
  end

endmodule
